// File: rtl/char_pkg.sv
// Shared constants and FSM state type for the character renderer.
package char_pkg;
   localparam int COLS        = 40;
   localparam int ROWS        = 30;
   localparam int NUM_GLYPHS  = 40;
   localparam int GLYPH_LINES = 8;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      LATCH,
      WRITE
   } state_t;
endpackage

// File: rtl/char_renderer.sv
// Renders one 8x8 glyph per command into a byte-per-line framebuffer,
// fetching the bitmap from an external registered character memory.
module char_renderer #(
   parameter int COLS  = char_pkg::COLS,
   parameter int ROWS  = char_pkg::ROWS,
   parameter int FB_AW = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [5:0]       cmd_char,
   input  logic [5:0]       cmd_col,
   input  logic [4:0]       cmd_row,
   output logic             charprint,
   output logic [5:0]       character,
   input  logic [63:0]      vdata,
   output logic             fb_we,
   output logic [FB_AW-1:0] fb_addr,
   output logic [7:0]       fb_wdata,
   output logic             cmd_err
);
   import char_pkg::*;

   localparam logic [FB_AW-1:0] LINE_STRIDE = FB_AW'(COLS);
   localparam logic [FB_AW-1:0] ROW_STRIDE  = FB_AW'(GLYPH_LINES * COLS);
   localparam logic [2:0]       LAST_LINE   = 3'(GLYPH_LINES - 1);

   state_t            state_reg, state_next;
   logic [2:0]        line_cnt_reg, line_cnt_next;
   logic [63:0]       line_reg, line_next;
   logic              charprint_reg, charprint_next;
   logic [5:0]        character_reg, character_next;
   logic              fb_we_reg, fb_we_next;
   logic [FB_AW-1:0]  fb_addr_reg, fb_addr_next;
   logic [7:0]        fb_wdata_reg, fb_wdata_next;
   logic              cmd_err_reg, cmd_err_next;

   logic              pos_ok;
   logic              glyph_ok;
   logic [FB_AW-1:0]  base_addr;

   assign pos_ok    = (int'(cmd_col) < COLS) && (int'(cmd_row) < ROWS);
   assign glyph_ok  = int'(cmd_char) < NUM_GLYPHS;
   // Row stride is a constant, so this is a constant multiply only.
   assign base_addr = FB_AW'(cmd_row) * ROW_STRIDE + FB_AW'(cmd_col);

   always_comb begin
      state_next     = state_reg;
      line_cnt_next  = line_cnt_reg;
      line_next      = line_reg;
      charprint_next = 1'b0;
      character_next = character_reg;
      fb_we_next     = 1'b0;
      fb_addr_next   = fb_addr_reg;
      fb_wdata_next  = fb_wdata_reg;
      cmd_err_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               if (!pos_ok) begin
                  cmd_err_next = 1'b1;
               end else begin
                  fb_addr_next  = base_addr;
                  line_cnt_next = 3'd0;
                  if (glyph_ok) begin
                     state_next     = FETCH;
                     charprint_next = 1'b1;
                     character_next = cmd_char;
                  end else begin
                     // Blank glyph: go straight to writing zero lines.
                     state_next    = WRITE;
                     fb_we_next    = 1'b1;
                     fb_wdata_next = 8'h00;
                     line_next     = '0;
                  end
               end
            end
         end
         FETCH: begin
            state_next = LATCH;
         end
         LATCH: begin
            state_next    = WRITE;
            fb_we_next    = 1'b1;
            fb_wdata_next = vdata[63:56];
            line_next     = {vdata[55:0], 8'h00};
         end
         WRITE: begin
            if (line_cnt_reg == LAST_LINE) begin
               state_next = IDLE;
            end else begin
               fb_we_next    = 1'b1;
               fb_addr_next  = fb_addr_reg + LINE_STRIDE;
               fb_wdata_next = line_reg[63:56];
               line_next     = {line_reg[55:0], 8'h00};
               line_cnt_next = line_cnt_reg + 3'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         line_cnt_reg  <= 3'd0;
         line_reg      <= '0;
         charprint_reg <= 1'b0;
         character_reg <= 6'd0;
         fb_we_reg     <= 1'b0;
         fb_addr_reg   <= '0;
         fb_wdata_reg  <= 8'h00;
         cmd_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         line_cnt_reg  <= line_cnt_next;
         line_reg      <= line_next;
         charprint_reg <= charprint_next;
         character_reg <= character_next;
         fb_we_reg     <= fb_we_next;
         fb_addr_reg   <= fb_addr_next;
         fb_wdata_reg  <= fb_wdata_next;
         cmd_err_reg   <= cmd_err_next;
      end
   end

   assign cmd_ready = (state_reg == IDLE);
   assign charprint = charprint_reg;
   assign character = character_reg;
   assign fb_we     = fb_we_reg;
   assign fb_addr   = fb_addr_reg;
   assign fb_wdata  = fb_wdata_reg;
   assign cmd_err   = cmd_err_reg;
endmodule

// File: tb/tb_char_renderer.sv
// Self-checking bench for char_renderer with a behavioural character memory
// and a cycle-indexed reference model of the render timing.
module tb_char_renderer;
   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int FB_AW = 14;
   localparam int NCAP  = 14;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [5:0]       cmd_char = '0;
   logic [5:0]       cmd_col = '0;
   logic [4:0]       cmd_row = '0;
   logic             charprint;
   logic [5:0]       character;
   logic [63:0]      vdata = '0;
   logic             fb_we;
   logic [FB_AW-1:0] fb_addr;
   logic [7:0]       fb_wdata;
   logic             cmd_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] rom [0:63];

   logic             tr_cp   [1:NCAP];
   logic [5:0]       tr_ch   [1:NCAP];
   logic             tr_we   [1:NCAP];
   logic [FB_AW-1:0] tr_addr [1:NCAP];
   logic [7:0]       tr_data [1:NCAP];
   logic             tr_err  [1:NCAP];
   logic             tr_rdy  [1:NCAP];

   always #5 clk = ~clk;

   char_renderer #(.COLS(COLS), .ROWS(ROWS), .FB_AW(FB_AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_char  (cmd_char),
      .cmd_col   (cmd_col),
      .cmd_row   (cmd_row),
      .charprint (charprint),
      .character (character),
      .vdata     (vdata),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .cmd_err   (cmd_err)
   );

   // Character memory: registered read, data valid the cycle after charprint.
   always @(posedge clk) if (charprint) vdata <= rom[character];

   // Reference model: expected outputs in cycle Ci after the accept cycle C0.
   function automatic bit m_legal(input int col, input int row);
      return (col < COLS) && (row < ROWS);
   endfunction
   function automatic int m_first(input int code);
      return (code < 40) ? 3 : 1;
   endfunction
   function automatic bit m_we(input int code, input int col, input int row, input int i);
      return m_legal(col, row) && (i >= m_first(code)) && (i < m_first(code) + 8);
   endfunction
   function automatic int m_addr(input int code, input int col, input int row, input int i);
      return row * 8 * COLS + col + (i - m_first(code)) * COLS;
   endfunction
   function automatic logic [7:0] m_data(input int code, input int i);
      int k;
      k = i - m_first(code);
      if (code >= 40) return 8'h00;
      return 8'((rom[code] >> (56 - 8 * k)) & 64'hFF);
   endfunction
   function automatic bit m_cp(input int code, input int col, input int row, input int i);
      return m_legal(col, row) && (code < 40) && (i == 1);
   endfunction
   function automatic bit m_err(input int col, input int row, input int i);
      return !m_legal(col, row) && (i == 1);
   endfunction
   function automatic bit m_rdy(input int code, input int col, input int row, input int i);
      if (!m_legal(col, row)) return 1'b1;
      return i >= ((code < 40) ? 11 : 9);
   endfunction

   // Present a command, wait for the handshake, then record C1..C14.
   task automatic issue(input int code, input int col, input int row,
                        input bit hold, input int ncode, input int ncol, input int nrow,
                        input int rst_at);
      int t;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_char  = 6'(code);
      cmd_col   = 6'(col);
      cmd_row   = 5'(row);
      t = 0;
      while (!cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL handshake_timeout: cmd_ready=%0b required 1", cmd_ready);
      end
      @(posedge clk);
      for (int i = 1; i <= NCAP; i++) begin
         @(negedge clk);
         tr_cp[i]   = charprint;
         tr_ch[i]   = character;
         tr_we[i]   = fb_we;
         tr_addr[i] = fb_addr;
         tr_data[i] = fb_wdata;
         tr_err[i]  = cmd_err;
         tr_rdy[i]  = cmd_ready;
         if (i == 1) begin
            if (hold) begin
               cmd_char = 6'(ncode);
               cmd_col  = 6'(ncol);
               cmd_row  = 5'(nrow);
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (rst_at != 0 && i == rst_at)     reset = 1'b1;
         if (rst_at != 0 && i == rst_at + 2) reset = 1'b0;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b1;
      cmd_char = 6'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp += 7;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", cmd_ready); end
      if (charprint !== 1'b0) begin n_bad++; $display("FAIL rst_charprint: got %0b want 0", charprint); end
      if (fb_we !== 1'b0)     begin n_bad++; $display("FAIL rst_fb_we: got %0b want 0", fb_we); end
      if (cmd_err !== 1'b0)   begin n_bad++; $display("FAIL rst_cmd_err: got %0b want 0", cmd_err); end
      if (character !== 6'd0) begin n_bad++; $display("FAIL rst_character: got %0d want 0", character); end
      if (fb_addr !== '0)     begin n_bad++; $display("FAIL rst_fb_addr: got %0d want 0", fb_addr); end
      if (fb_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_fb_wdata: got %02h want 00", fb_wdata); end
      cmd_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      n_cmp += 2;
      if (charprint !== 1'b0) begin n_bad++; $display("FAIL rst_priority_cp: got %0b want 0", charprint); end
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_priority_rdy: got %0b want 1", cmd_ready); end
   endtask

   task automatic test_glyph5();
      logic [7:0] bytes [0:7];
      bytes = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
      issue(5, 3, 2, 1'b0, 0, 0, 0, 0);
      n_cmp += 6;
      if (tr_cp[1] !== 1'b1)  begin n_bad++; $display("FAIL g5_charprint_c1: got %0b want 1", tr_cp[1]); end
      if (tr_ch[1] !== 6'd5)  begin n_bad++; $display("FAIL g5_character: got %0d want 5", tr_ch[1]); end
      if (tr_cp[2] !== 1'b0)  begin n_bad++; $display("FAIL g5_charprint_c2: got %0b want 0", tr_cp[2]); end
      if (tr_we[2] !== 1'b0)  begin n_bad++; $display("FAIL g5_we_c2: got %0b want 0", tr_we[2]); end
      if (tr_we[11] !== 1'b0) begin n_bad++; $display("FAIL g5_we_c11: got %0b want 0", tr_we[11]); end
      if (tr_rdy[11] !== 1'b1 || tr_rdy[10] !== 1'b0) begin
         n_bad++; $display("FAIL g5_ready: got c10=%0b c11=%0b want 0 1", tr_rdy[10], tr_rdy[11]);
      end
      for (int k = 0; k < 8; k++) begin
         n_cmp += 3;
         if (tr_we[3+k] !== 1'b1) begin n_bad++; $display("FAIL g5_we line%0d: got %0b want 1", k, tr_we[3+k]); end
         if (int'(tr_addr[3+k]) != 643 + 40 * k) begin
            n_bad++; $display("FAIL g5_addr line%0d: got %0d want %0d", k, tr_addr[3+k], 643 + 40 * k);
         end
         if (tr_data[3+k] !== bytes[k]) begin
            n_bad++; $display("FAIL g5_data line%0d: got %02h want %02h", k, tr_data[3+k], bytes[k]);
         end
      end
   endtask

   task automatic test_blank();
      issue(45, 0, 0, 1'b0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         n_cmp += 2;
         if (tr_cp[i] !== 1'b0) begin n_bad++; $display("FAIL blank_charprint c%0d: got %0b want 0", i, tr_cp[i]); end
         if (tr_we[i] !== (i <= 8)) begin n_bad++; $display("FAIL blank_we c%0d: got %0b want %0b", i, tr_we[i], i <= 8); end
         if (i <= 8) begin
            n_cmp += 2;
            if (int'(tr_addr[i]) != 40 * (i - 1)) begin
               n_bad++; $display("FAIL blank_addr c%0d: got %0d want %0d", i, tr_addr[i], 40 * (i - 1));
            end
            if (tr_data[i] !== 8'h00) begin n_bad++; $display("FAIL blank_data c%0d: got %02h want 00", i, tr_data[i]); end
         end
      end
      n_cmp++;
      if (tr_rdy[8] !== 1'b0 || tr_rdy[9] !== 1'b1) begin
         n_bad++; $display("FAIL blank_ready: got c8=%0b c9=%0b want 0 1", tr_rdy[8], tr_rdy[9]);
      end
   endtask

   task automatic test_illegal();
      int cs [0:2][0:2];
      cs = '{'{7, 40, 0}, '{7, 0, 30}, '{50, 45, 31}};
      for (int c = 0; c < 3; c++) begin
         issue(cs[c][0], cs[c][1], cs[c][2], 1'b0, 0, 0, 0, 0);
         for (int i = 1; i <= 12; i++) begin
            n_cmp += 4;
            if (tr_err[i] !== (i == 1)) begin n_bad++; $display("FAIL illegal%0d_err c%0d: got %0b want %0b", c, i, tr_err[i], i == 1); end
            if (tr_we[i] !== 1'b0)  begin n_bad++; $display("FAIL illegal%0d_we c%0d: got %0b want 0", c, i, tr_we[i]); end
            if (tr_cp[i] !== 1'b0)  begin n_bad++; $display("FAIL illegal%0d_cp c%0d: got %0b want 0", c, i, tr_cp[i]); end
            if (tr_rdy[i] !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_rdy c%0d: got %0b want 1", c, i, tr_rdy[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      issue(1, 0, 0, 1'b1, 2, 1, 0, 0);
      n_cmp += 9;
      if (tr_we[3] !== 1'b1 || tr_addr[3] !== '0) begin
         n_bad++; $display("FAIL b2b_first_write: got we=%0b addr=%0d want 1 0", tr_we[3], tr_addr[3]);
      end
      if (tr_rdy[11] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_c11: got %0b want 1", tr_rdy[11]); end
      if (tr_rdy[12] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_c12: got %0b want 0", tr_rdy[12]); end
      if (tr_cp[12] !== 1'b1)  begin n_bad++; $display("FAIL b2b_charprint_c12: got %0b want 1", tr_cp[12]); end
      if (tr_ch[12] !== 6'd2)  begin n_bad++; $display("FAIL b2b_character_c12: got %0d want 2", tr_ch[12]); end
      if (tr_we[13] !== 1'b0)  begin n_bad++; $display("FAIL b2b_we_c13: got %0b want 0", tr_we[13]); end
      if (tr_we[14] !== 1'b1)  begin n_bad++; $display("FAIL b2b_we_c14: got %0b want 1", tr_we[14]); end
      if (int'(tr_addr[14]) != 1) begin n_bad++; $display("FAIL b2b_addr_c14: got %0d want 1", tr_addr[14]); end
      if (tr_data[14] !== m_data(2, 3)) begin
         n_bad++; $display("FAIL b2b_data_c14: got %02h want %02h", tr_data[14], m_data(2, 3));
      end
   endtask

   task automatic test_reset_mid();
      int code, col, row;
      issue(9, 10, 5, 1'b0, 0, 0, 0, 5);
      for (int i = 3; i <= 5; i++) begin
         n_cmp++;
         if (tr_we[i] !== 1'b1) begin n_bad++; $display("FAIL rmid_we_pre c%0d: got %0b want 1", i, tr_we[i]); end
      end
      for (int i = 6; i <= NCAP; i++) begin
         n_cmp += 3;
         if (tr_we[i] !== 1'b0)  begin n_bad++; $display("FAIL rmid_we_post c%0d: got %0b want 0", i, tr_we[i]); end
         if (tr_cp[i] !== 1'b0)  begin n_bad++; $display("FAIL rmid_cp_post c%0d: got %0b want 0", i, tr_cp[i]); end
         if (tr_rdy[i] !== 1'b1) begin n_bad++; $display("FAIL rmid_rdy_post c%0d: got %0b want 1", i, tr_rdy[i]); end
      end
      code = 12; col = 20; row = 20;
      issue(code, col, row, 1'b0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         n_cmp += 2;
         if (tr_we[i] !== m_we(code, col, row, i)) begin
            n_bad++; $display("FAIL rmid_new_we c%0d: got %0b want %0b", i, tr_we[i], m_we(code, col, row, i));
         end
         if (tr_cp[i] !== m_cp(code, col, row, i)) begin
            n_bad++; $display("FAIL rmid_new_cp c%0d: got %0b want %0b", i, tr_cp[i], m_cp(code, col, row, i));
         end
         if (m_we(code, col, row, i)) begin
            n_cmp += 2;
            if (int'(tr_addr[i]) != m_addr(code, col, row, i)) begin
               n_bad++; $display("FAIL rmid_new_addr c%0d: got %0d want %0d", i, tr_addr[i], m_addr(code, col, row, i));
            end
            if (tr_data[i] !== m_data(code, i)) begin
               n_bad++; $display("FAIL rmid_new_data c%0d: got %02h want %02h", i, tr_data[i], m_data(code, i));
            end
         end
      end
   endtask

   task automatic test_corner();
      int code;
      code = int'($urandom_range(0, 39));
      issue(code, 39, 29, 1'b0, 0, 0, 0, 0);
      n_cmp += 3;
      if (tr_we[10] !== 1'b1) begin n_bad++; $display("FAIL corner_we_c10: got %0b want 1", tr_we[10]); end
      if (int'(tr_addr[10]) != 9599) begin n_bad++; $display("FAIL corner_addr_c10: got %0d want 9599", tr_addr[10]); end
      if (tr_we[11] !== 1'b0) begin n_bad++; $display("FAIL corner_we_c11: got %0b want 0", tr_we[11]); end
      issue(60, 39, 29, 1'b0, 0, 0, 0, 0);
      n_cmp += 2;
      if (tr_we[8] !== 1'b1 || int'(tr_addr[8]) != 9599) begin
         n_bad++; $display("FAIL corner_blank_c8: got we=%0b addr=%0d want 1 9599", tr_we[8], tr_addr[8]);
      end
      if (tr_we[9] !== 1'b0) begin n_bad++; $display("FAIL corner_blank_we_c9: got %0b want 0", tr_we[9]); end
   endtask

   task automatic test_random();
      int code, col, row;
      for (int n = 0; n < 25; n++) begin
         code = int'($urandom_range(0, 63));
         col  = int'($urandom_range(0, 45));
         row  = int'($urandom_range(0, 33));
         issue(code, col, row, 1'b0, 0, 0, 0, 0);
         for (int i = 1; i <= 12; i++) begin
            n_cmp += 4;
            if (tr_we[i] !== m_we(code, col, row, i)) begin
               n_bad++; $display("FAIL rand%0d_we c%0d (ch%0d col%0d row%0d): got %0b want %0b", n, i, code, col, row, tr_we[i], m_we(code, col, row, i));
            end
            if (tr_cp[i] !== m_cp(code, col, row, i)) begin
               n_bad++; $display("FAIL rand%0d_cp c%0d: got %0b want %0b", n, i, tr_cp[i], m_cp(code, col, row, i));
            end
            if (tr_err[i] !== m_err(col, row, i)) begin
               n_bad++; $display("FAIL rand%0d_err c%0d: got %0b want %0b", n, i, tr_err[i], m_err(col, row, i));
            end
            if (tr_rdy[i] !== m_rdy(code, col, row, i)) begin
               n_bad++; $display("FAIL rand%0d_rdy c%0d: got %0b want %0b", n, i, tr_rdy[i], m_rdy(code, col, row, i));
            end
            if (m_cp(code, col, row, i)) begin
               n_cmp++;
               if (int'(tr_ch[i]) != code) begin
                  n_bad++; $display("FAIL rand%0d_character c%0d: got %0d want %0d", n, i, tr_ch[i], code);
               end
            end
            if (m_we(code, col, row, i)) begin
               n_cmp += 2;
               if (int'(tr_addr[i]) != m_addr(code, col, row, i)) begin
                  n_bad++; $display("FAIL rand%0d_addr c%0d: got %0d want %0d", n, i, tr_addr[i], m_addr(code, col, row, i));
               end
               if (tr_data[i] !== m_data(code, i)) begin
                  n_bad++; $display("FAIL rand%0d_data c%0d: got %02h want %02h", n, i, tr_data[i], m_data(code, i));
               end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = {$urandom, $urandom};
      rom[5] = 64'h183C66667E666600;
      test_reset();
      test_glyph5();
      test_blank();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_corner();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
